// File: rtl/fir_arbiter.sv
// Packet-level round-robin arbiter sharing one FIR datapath between NUM_REQ
// AXI-stream requesters. Each grant is recorded in an in-order route FIFO so
// that every FIR output packet is steered back to the requester that sent the
// matching input packet.
module fir_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ROUTE_DEPTH = 4
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [NUM_REQ-1:0]              S_AXIS_TVALID,
  input  logic [NUM_REQ-1:0]              S_AXIS_TLAST,
  output logic [NUM_REQ-1:0]              S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]           FIR_RDATA,
  input  logic                            FIR_RVALID,
  input  logic                            FIR_RLAST,
  output logic                            FIR_RREADY,
  output logic [NUM_REQ*DATA_WIDTH-1:0]   S_AXIS_RDATA,
  output logic [NUM_REQ-1:0]              S_AXIS_RVALID,
  output logic [NUM_REQ-1:0]              S_AXIS_RLAST,
  input  logic [NUM_REQ-1:0]              S_AXIS_RREADY,
  output logic [$clog2(NUM_REQ)-1:0]      GRANT,
  output logic                            BUSY,
  output logic [$clog2(ROUTE_DEPTH):0]    ROUTE_COUNT
);

  localparam int unsigned GrantW = $clog2(NUM_REQ);
  localparam int unsigned PtrW   = $clog2(ROUTE_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(ROUTE_DEPTH);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [GrantW-1:0]   grant_q, grant_d;
  logic [GrantW-1:0]   last_grant_q, last_grant_d;
  logic [GrantW-1:0]   route_mem_q [ROUTE_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q;

  logic [GrantW-1:0]   up_sel, low_sel, arb_sel;
  logic                up_found, arb_found;
  logic                push, pop, in_last, route_empty;
  logic [GrantW-1:0]   head;

  // Round-robin pick: lowest valid index above last_grant, else lowest valid overall.
  always_comb begin
    up_sel   = '0;
    low_sel  = '0;
    up_found = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (S_AXIS_TVALID[i]) begin
        low_sel = GrantW'(i);
        if (GrantW'(i) > last_grant_q) begin
          up_sel   = GrantW'(i);
          up_found = 1'b1;
        end
      end
    end
    arb_sel   = up_found ? up_sel : low_sel;
    arb_found = |S_AXIS_TVALID;
  end

  // Forward the granted requester to the FIR input while a packet is in progress.
  always_comb begin
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    if (state_q == StBusy) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (grant_q == GrantW'(i)) begin
          M_AXIS_TDATA     = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
          M_AXIS_TVALID    = S_AXIS_TVALID[i];
          M_AXIS_TLAST     = S_AXIS_TLAST[i];
          S_AXIS_TREADY[i] = M_AXIS_TREADY;
        end
      end
    end
  end

  assign in_last = (state_q == StBusy) & M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
  assign push    = (state_q == StIdle) & arb_found & (cnt_q < FullCount);

  // Arbitration FSM next state.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (push) begin
          grant_d = arb_sel;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (in_last) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign route_empty = (cnt_q == '0);
  assign head        = route_mem_q[rd_ptr_q];

  // Steer the FIR output to the requester at the head of the route FIFO.
  always_comb begin
    S_AXIS_RVALID = '0;
    S_AXIS_RLAST  = '0;
    FIR_RREADY    = 1'b0;
    if (!route_empty) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (head == GrantW'(i)) begin
          S_AXIS_RVALID[i] = FIR_RVALID;
          S_AXIS_RLAST[i]  = FIR_RLAST;
          FIR_RREADY       = S_AXIS_RREADY[i];
        end
      end
    end
  end

  assign pop          = FIR_RVALID & FIR_RREADY & FIR_RLAST;
  assign S_AXIS_RDATA = {NUM_REQ{FIR_RDATA}};

  // State, grant and route FIFO pointers; reset abandons any packet in flight.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GrantW'(NUM_REQ - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Route storage; entries are only read while the occupancy count covers them.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) route_mem_q[wr_ptr_q] <= arb_sel;
  end

  assign GRANT       = grant_q;
  assign BUSY        = (state_q == StBusy);
  assign ROUTE_COUNT = cnt_q;

endmodule
